// File: rtl/dpram_req_arbiter_if.sv
// One requester's port onto the shared data RAM: request channel plus the
// unconditional one-cycle-later response channel.
interface dpram_req_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // Handshake: a request transfers in any cycle where valid && ready. While
  // valid is high and ready low, the requester holds we/addr/wdata stable.
  // ready may depend combinationally on valid. rsp_valid has no backpressure.
  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH/8-1:0] we;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    rsp_valid;
  logic [DATA_WIDTH-1:0]   rsp_rdata;

  modport master (
    output valid, we, addr, wdata,
    input  ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  valid, we, addr, wdata,
    output ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/dpram_req_arbiter.sv
// Round-robin arbiter for the LSU and host requesters onto the data RAM's
// write/read port pair. The fromhost mailbox is initialised once after reset.
module dpram_req_arbiter #(
  parameter int                         LSU_ADDR_WIDTH = 32,
  parameter int                         LSU_DATA_WIDTH = 32,
  parameter logic [LSU_ADDR_WIDTH-1:0]  FROMHOST_ADDR  = 'h1040
) (
  input  logic                        clk,
  input  logic                        rst,
  dpram_req_arbiter_if.slave          l,
  dpram_req_arbiter_if.slave          h,
  output logic [LSU_DATA_WIDTH/8-1:0] mem_we,
  output logic [LSU_ADDR_WIDTH-1:0]   mem_waddr,
  output logic [LSU_DATA_WIDTH-1:0]   mem_din,
  output logic [LSU_ADDR_WIDTH-1:0]   mem_raddr,
  input  logic [LSU_DATA_WIDTH-1:0]   mem_dout,
  output logic [1:0]                  state_dbg
);

  localparam int NB = LSU_DATA_WIDTH / 8;
  localparam int INIT_LANE = int'(FROMHOST_ADDR % LSU_ADDR_WIDTH'(NB));
  localparam logic [NB-1:0]             INIT_WE  = NB'(1) << INIT_LANE;
  localparam logic [LSU_DATA_WIDTH-1:0] INIT_DIN = LSU_DATA_WIDTH'(1) << (8 * INIT_LANE);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_INIT  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   prio_q, prio_d;          // 0: LSU wins contention, 1: host wins
  logic   rsp_v_q, rsp_v_d;
  logic   rsp_own_q, rsp_own_d;    // 0: LSU, 1: host
  logic   rsp_rd_q, rsp_rd_d;
  logic   gnt_l, gnt_h;

  logic [NB-1:0]             win_we;
  logic [LSU_ADDR_WIDTH-1:0] win_addr;
  logic [LSU_DATA_WIDTH-1:0] win_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RESET;
      prio_q    <= 1'b0;
      rsp_v_q   <= 1'b0;
      rsp_own_q <= 1'b0;
      rsp_rd_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      rsp_v_q   <= rsp_v_d;
      rsp_own_q <= rsp_own_d;
      rsp_rd_q  <= rsp_rd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    rsp_v_d   = 1'b0;
    rsp_own_d = 1'b0;
    rsp_rd_d  = 1'b0;
    gnt_l     = 1'b0;
    gnt_h     = 1'b0;
    win_we    = '0;
    win_addr  = '0;
    win_wdata = '0;
    mem_we    = '0;
    mem_waddr = '0;
    mem_din   = '0;
    mem_raddr = '0;

    case (state_q)
      ST_RESET: state_d = ST_INIT;
      ST_INIT: begin
        state_d   = ST_RUN;
        mem_we    = INIT_WE;
        mem_waddr = FROMHOST_ADDR;
        mem_din   = INIT_DIN;
      end
      ST_RUN: begin
        gnt_l = l.valid && (!h.valid || !prio_q);
        gnt_h = h.valid && (!l.valid || prio_q);
        // After contention the loser is favoured next time.
        if (l.valid && h.valid) prio_d = gnt_l;
        if (gnt_l || gnt_h) begin
          win_we    = gnt_h ? h.we    : l.we;
          win_addr  = gnt_h ? h.addr  : l.addr;
          win_wdata = gnt_h ? h.wdata : l.wdata;
          rsp_v_d   = 1'b1;
          rsp_own_d = gnt_h;
          rsp_rd_d  = (win_we == '0);
          if (rsp_rd_d) begin
            mem_raddr = win_addr;
          end else begin
            mem_we    = win_we;
            mem_waddr = win_addr;
            mem_din   = win_wdata;
          end
        end
      end
      default: state_d = ST_RESET;
    endcase
  end

  logic l_rsp_v, h_rsp_v;
  assign l_rsp_v = rsp_v_q && !rsp_own_q;
  assign h_rsp_v = rsp_v_q &&  rsp_own_q;

  assign l.ready     = gnt_l;
  assign h.ready     = gnt_h;
  assign l.rsp_valid = l_rsp_v;
  assign h.rsp_valid = h_rsp_v;
  // Read data is only ever forwarded to the owner of a read response.
  assign l.rsp_rdata = (l_rsp_v && rsp_rd_q) ? mem_dout : '0;
  assign h.rsp_rdata = (h_rsp_v && rsp_rd_q) ? mem_dout : '0;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_dpram_req_arbiter.sv
// Bench for dpram_req_arbiter: directed scenarios plus random traffic against
// a byte-level memory model with round-robin contention rules.
module tb_dpram_req_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NB = DW / 8;

  typedef struct {
    bit          v;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dpram_req_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) l_if ();
  dpram_req_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) h_if ();

  logic [NB-1:0] mem_we;
  logic [AW-1:0] mem_waddr, mem_raddr;
  logic [DW-1:0] mem_din, mem_dout;
  logic [1:0]    state_dbg;

  dpram_req_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .l         (l_if),
    .h         (h_if),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_din   (mem_din),
    .mem_raddr (mem_raddr),
    .mem_dout  (mem_dout),
    .state_dbg (state_dbg)
  );

  // Simulation RAM: byte-masked write, registered read.
  logic [DW-1:0] ram [0:4095];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] we);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = we[b] ? d[8*b +: 8] : old[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (mem_we != '0) ram[mem_waddr[13:2]] <= merge(ram[mem_waddr[13:2]], mem_din, mem_we);
    mem_dout <= ram[mem_raddr[13:2]];
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_bad    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  logic [7:0]  m_mem [int];
  bit          m_h_turn;
  logic [31:0] exp_l_q [$];
  logic [31:0] exp_h_q [$];

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] r;
    int base;
    base = int'(a[13:2]) * 4;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = m_mem.exists(base + b) ? m_mem[base + b] : 8'h00;
    return r;
  endfunction

  task automatic m_write(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
    int base;
    base = int'(a[13:2]) * 4;
    for (int b = 0; b < 4; b++) if (we[b]) m_mem[base + b] = d[8*b +: 8];
  endtask

  function automatic req_t rq(input bit v, input logic [3:0] we, input logic [31:0] a,
                              input logic [31:0] d);
    req_t r;
    r.v = v; r.we = we; r.addr = a; r.wdata = d;
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input req_t lr, input req_t hr);
    l_if.valid = lr.v; l_if.we = lr.we; l_if.addr = lr.addr; l_if.wdata = lr.wdata;
    h_if.valid = hr.v; h_if.we = hr.we; h_if.addr = hr.addr; h_if.wdata = hr.wdata;
  endtask

  task automatic check_rsp(input bit gl, input bit gh);
    check("l_rsp_valid", 32'(l_if.rsp_valid), 32'(gl));
    check("h_rsp_valid", 32'(h_if.rsp_valid), 32'(gh));
    check("l_rsp_rdata", l_if.rsp_rdata, gl ? exp_l_q.pop_front() : 32'h0);
    check("h_rsp_rdata", h_if.rsp_rdata, gh ? exp_h_q.pop_front() : 32'h0);
  endtask

  // One RUN cycle: drive, check grant and RAM port, then check the response.
  task automatic cycle(input req_t lr, input req_t hr, output bit gl, output bit gh);
    req_t w;
    logic [31:0] e;
    drive(lr, hr);
    #1;
    if (lr.v && hr.v) begin
      gl = !m_h_turn;
      gh = m_h_turn;
      m_h_turn = gl;
    end else begin
      gl = lr.v;
      gh = hr.v;
    end
    check("l_ready", 32'(l_if.ready), 32'(gl));
    check("h_ready", 32'(h_if.ready), 32'(gh));
    if (gl || gh) begin
      w = gl ? lr : hr;
      if (w.we == 4'h0) begin
        check("rd_raddr", mem_raddr, w.addr);
        check("rd_mem_we", 32'(mem_we), 32'h0);
        e = m_read(w.addr);
      end else begin
        check("wr_mem_we", 32'(mem_we), 32'(w.we));
        check("wr_waddr", mem_waddr, w.addr);
        check("wr_din", mem_din, w.wdata);
        check("wr_raddr", mem_raddr, 32'h0);
        m_write(w.addr, w.we, w.wdata);
        e = 32'h0;
      end
      if (gl) exp_l_q.push_back(e);
      else    exp_h_q.push_back(e);
    end else begin
      check("idle_mem_we", 32'(mem_we), 32'h0);
      check("idle_raddr", mem_raddr, 32'h0);
      check("idle_waddr", mem_waddr, 32'h0);
    end
    @(posedge clk); #1;
    check_rsp(gl, gh);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_l_ready"}, 32'(l_if.ready), 32'h0);
    check({tag, "_h_ready"}, 32'(h_if.ready), 32'h0);
    check({tag, "_l_rsp_valid"}, 32'(l_if.rsp_valid), 32'h0);
    check({tag, "_h_rsp_valid"}, 32'(h_if.rsp_valid), 32'h0);
    check({tag, "_l_rsp_rdata"}, l_if.rsp_rdata, 32'h0);
    check({tag, "_h_rsp_rdata"}, h_if.rsp_rdata, 32'h0);
    check({tag, "_raddr"}, mem_raddr, 32'h0);
  endtask

  // Reset for n cycles with valids optionally held high, then verify INIT.
  task automatic do_reset(input int n, input bit dirty);
    rst = 1'b1;
    drive(rq(dirty, 4'h0, 32'h100, 32'h0), rq(dirty, 4'h0, 32'h104, 32'h0));
    repeat (n) @(posedge clk);
    #1;
    check("rst_state", 32'(state_dbg), 32'd0);
    check_quiet("rst");
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_waddr", mem_waddr, 32'h0);
    check("rst_din", mem_din, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_quiet("init");
    check("init_mem_we", 32'(mem_we), 32'h1);
    check("init_waddr", mem_waddr, 32'h1040);
    check("init_din", mem_din, 32'h1);
    m_write(32'h1040, 4'h1, 32'h1);
    m_h_turn = 1'b0;
    exp_l_q.delete();
    exp_h_q.delete();
    drive(rq(0, 4'h0, 32'h0, 32'h0), rq(0, 4'h0, 32'h0, 32'h0));
    @(posedge clk); #1;
    check("run_state", 32'(state_dbg), 32'd2);
  endtask

  function automatic req_t rand_req();
    logic [3:0] we;
    we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
    return rq(1'b1, we, 32'h200 + 32'($urandom_range(0, 15)) * 4, $urandom);
  endfunction

  task automatic random_traffic(input int n);
    req_t lp, hp;
    bit gl, gh;
    lp = rq(0, 4'h0, 32'h0, 32'h0);
    hp = lp;
    for (int i = 0; i < n; i++) begin
      if (!lp.v && $urandom_range(0, 9) < 7) lp = rand_req();
      if (!hp.v && $urandom_range(0, 9) < 6) hp = rand_req();
      cycle(lp, hp, gl, gh);
      if (gl) lp.v = 1'b0;
      if (gh) hp.v = 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  req_t idle, lrd, hrd;
  bit   gl, gh;

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = '0;
    idle = rq(0, 4'h0, 32'h0, 32'h0);
    drive(idle, idle);
    do_reset(3, 1'b1);

    // LSU write then read-back on the next cycle
    cycle(rq(1, 4'hF, 32'h100, 32'hDEADBEEF), idle, gl, gh);
    cycle(rq(1, 4'h0, 32'h100, 32'h0), idle, gl, gh);
    cycle(idle, idle, gl, gh);

    // Contention: L, H, L, H
    for (int i = 0; i < 4; i++)
      cycle(rq(1, 4'h0, 32'h100, 32'h0), rq(1, 4'h0, 32'h1040, 32'h0), gl, gh);

    // Host-only grants leave priority with LSU
    for (int i = 0; i < 3; i++) cycle(idle, rq(1, 4'h0, 32'h1040, 32'h0), gl, gh);
    cycle(rq(1, 4'h0, 32'h100, 32'h0), rq(1, 4'h0, 32'h100, 32'h0), gl, gh);
    cycle(idle, rq(1, 4'h0, 32'h100, 32'h0), gl, gh);

    // Byte-masked write
    cycle(rq(1, 4'hF, 32'h20, 32'h0), idle, gl, gh);
    cycle(idle, rq(1, 4'b0100, 32'h20, 32'h11223344), gl, gh);
    cycle(rq(1, 4'h0, 32'h20, 32'h0), idle, gl, gh);
    cycle(idle, idle, gl, gh);

    random_traffic(300);

    // Leave priority with host, then reset with an LSU read in flight
    lrd = rq(1, 4'h0, 32'h100, 32'h0);
    hrd = rq(1, 4'h0, 32'h20, 32'h0);
    if (!m_h_turn) cycle(lrd, hrd, gl, gh);
    drive(lrd, idle);
    rst = 1'b1;
    #1;
    check("mid_l_ready", 32'(l_if.ready), 32'h1);
    @(posedge clk); #1;
    check("mid_l_rsp_dropped", 32'(l_if.rsp_valid), 32'h0);
    check("mid_state", 32'(state_dbg), 32'd0);
    do_reset(2, 1'b0);
    cycle(lrd, hrd, gl, gh);
    cycle(idle, idle, gl, gh);

    random_traffic(300);
    cycle(idle, idle, gl, gh);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  initial begin
    #200000;
    check("watchdog", 32'h0, 32'h1);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
